// File: rtl/avalon_mm_slave_responder.sv
// Avalon-MM slave responder: word memory, programmable wait states, fixed pipelined read latency.
// Optional access counters enabled by defining AVS_ACCESS_STATS_EN.
module avalon_mm_slave_responder #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 26,
  parameter int unsigned MEM_DEPTH    = 256,
  parameter int unsigned WAIT_CYCLES  = 2,
  parameter int unsigned READ_LATENCY = 3
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [ADDR_W-1:0]   i_address,
  input  logic                i_read,
  input  logic                i_write,
  input  logic [DATA_W-1:0]   i_writedata,
  input  logic [DATA_W/8-1:0] i_byteenable,
  output logic                o_waitrequest,
  output logic [DATA_W-1:0]   o_readdata,
  output logic                o_readdatavalid,
  output logic [1:0]          o_response,
  output logic [15:0]         o_rd_count,
  output logic [15:0]         o_wr_count
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned BE_W  = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCEPT} state_t;

  state_t                r_state;
  logic [3:0]            r_wcnt;
  logic                  r_waitrequest;

  logic [DATA_W-1:0]     r_mem [MEM_DEPTH];
  logic [READ_LATENCY-1:0] r_pv;
  logic [DATA_W-1:0]     r_pd   [READ_LATENCY];
  logic                  r_perr [READ_LATENCY];

  logic                  w_req;
  logic                  w_acc_wr;
  logic                  w_acc_rd;
  logic                  w_in_range;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_W-1:0]     w_rd_word;

  assign w_req      = i_read | i_write;
  assign w_acc_wr   = (r_state == S_ACCEPT) && i_write;
  assign w_acc_rd   = (r_state == S_ACCEPT) && i_read && !i_write;
  assign w_in_range = i_address < ADDR_W'(MEM_DEPTH);
  assign w_idx      = i_address[IDX_W-1:0];
  assign w_rd_word  = w_in_range ? r_mem[w_idx] : '0;

  // The counter is tested for 1 before decrementing so WAIT lasts exactly WAIT_CYCLES cycles.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_wcnt        <= '0;
      r_waitrequest <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (WAIT_CYCLES == 0) begin
              r_state       <= S_ACCEPT;
              r_waitrequest <= 1'b0;
            end else begin
              r_state <= S_WAIT;
              r_wcnt  <= 4'(WAIT_CYCLES);
            end
          end
        end
        S_WAIT: begin
          if (!w_req) begin
            r_state <= S_IDLE;
          end else if (r_wcnt == 4'd1) begin
            r_state       <= S_ACCEPT;
            r_waitrequest <= 1'b0;
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
          end
        end
        S_ACCEPT: begin
          r_state       <= S_IDLE;
          r_waitrequest <= 1'b1;
        end
        default: begin
          r_state       <= S_IDLE;
          r_waitrequest <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_acc_wr && w_in_range) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (i_byteenable[b]) r_mem[w_idx][8*b +: 8] <= i_writedata[8*b +: 8];
      end
    end
  end

  // Stage data only moves with a valid token, so the last stage holds readdata between pulses.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pv <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        r_pd[i]   <= '0;
        r_perr[i] <= 1'b0;
      end
    end else begin
      r_pv[0] <= w_acc_rd;
      if (w_acc_rd) begin
        r_pd[0]   <= w_rd_word;
        r_perr[0] <= !w_in_range;
      end
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        if (r_pv[i-1]) begin
          r_pd[i]   <= r_pd[i-1];
          r_perr[i] <= r_perr[i-1];
        end
      end
    end
  end

  assign o_waitrequest   = r_waitrequest;
  assign o_readdatavalid = r_pv[READ_LATENCY-1];
  assign o_readdata      = r_pd[READ_LATENCY-1];
  assign o_response      = {r_perr[READ_LATENCY-1], 1'b0};

`ifdef AVS_ACCESS_STATS_EN
  logic [15:0] r_rd_count;
  logic [15:0] r_wr_count;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_acc_rd && (r_rd_count != 16'hFFFF)) r_rd_count <= r_rd_count + 16'd1;
      if (w_acc_wr && (r_wr_count != 16'hFFFF)) r_wr_count <= r_wr_count + 16'd1;
    end
  end

  assign o_rd_count = r_rd_count;
  assign o_wr_count = r_wr_count;
`else
  assign o_rd_count = '0;
  assign o_wr_count = '0;
`endif

endmodule

// File: doc/avalon_mm_slave_responder.md
Name: avalon_mm_slave_responder

Overview:
- Avalon-MM slave that answers the read/write transactions issued by the FPGA-side bus master (26-bit word address, 32-bit data).
- Acts as the target end of the master's interface in simulation and on-board bring-up, backed by a small on-chip word memory.
- Inserts programmable wait states and a fixed pipelined read latency so master handshake handling is exercised.
- Returns an error response for addresses outside the implemented window.

Parameters:
- DATA_W, 32, data width in bits; multiple of 8.
- ADDR_W, 26, word address width.
- MEM_DEPTH, 256, implemented words; power of two.
- WAIT_CYCLES, 2, extra waitrequest-high cycles before accept; 0..15.
- READ_LATENCY, 3, cycles from accept edge to readdatavalid; 1..8.

Ports:
- clock  in  1  single system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  ADDR_W  word address.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  DATA_W  write data.
- byteenable  in  DATA_W/8  byte lane enables for writes.
- waitrequest  out  1  high = command not accepted this cycle.
- readdata  out  DATA_W  read data, valid with readdatavalid.
- readdatavalid  out  1  one-cycle pulse per accepted read.
- response  out  2  00 OKAY, 10 SLVERR; qualified by readdatavalid.
- rd_count  out  16  accepted reads (optional feature).
- wr_count  out  16  accepted writes (optional feature).

Behaviour:
- Reset values: waitrequest=1, readdatavalid=0, readdata=0, response=00, rd_count=0, wr_count=0, FSM=IDLE, read pipeline empty. Memory contents are not reset.
- FSM states:
  - IDLE: waitrequest=1. On (read|write), load wait counter with WAIT_CYCLES and go to WAIT; if WAIT_CYCLES=0, go directly to ACCEPT.
  - WAIT: waitrequest=1. Decrement the counter; at 0, go to ACCEPT. If read and write both drop, return to IDLE with no transaction.
  - ACCEPT: waitrequest=0 for exactly one cycle. The command is captured on this clock edge, then the FSM returns to IDLE.
- Throughput: minimum 2 cycles per command (WAIT_CYCLES=0); 2+WAIT_CYCLES cycles in general.
- Address decode: in range if address < MEM_DEPTH. Index = address[log2(MEM_DEPTH)-1:0].
- Write at accept:
  - In range: merge writedata into the word per byteenable lane; lanes with byteenable=0 are unchanged.
  - Out of range: write dropped, no response (writes have no response phase).
- Read at accept: address, range flag, and memory word enter a READ_LATENCY-deep shift pipeline.
  - readdatavalid pulses exactly READ_LATENCY cycles after the accept edge.
  - In range: readdata = stored word, response = 00.
  - Out of range: readdata = 0, response = 10.
- readdata holds its last value when readdatavalid=0.
- read and write both high at accept: write is performed, read is ignored, and no readdatavalid is generated.
- Write followed by read of the same address: the read returns the new data. The write commits at its accept edge, and the read accept comes at least 2 cycles later.
- Reset mid-operation: FSM goes to IDLE and the pipeline is flushed. No readdatavalid may appear after reset for reads accepted before reset.
- No outstanding-read limit is needed: at most one accept occurs per 2 cycles and the pipeline has no backpressure.

Optional Feature:
- Macro: AVS_ACCESS_STATS_EN.
- Defined: rd_count increments on each accepted read and wr_count on each accepted write, including out-of-range accesses. Both saturate at 0xFFFF and clear only on reset.
- Undefined: rd_count and wr_count are tied to 0 and no counter logic is synthesized.

Test Plan:
- Write 0xA5A5_1234 to address 0x10 with byteenable=4'hF, WAIT_CYCLES=2 -> waitrequest high for 3 cycles after request, then low for 1 cycle. Subsequent read of 0x10 -> readdatavalid exactly 3 cycles after accept, readdata=0xA5A5_1234, response=00.
- Byte-lane merge: write 0xFFFF_FFFF to address 0x20, then write 0x0000_0000 with byteenable=4'b0101 -> read returns 0xFF00_FF00.
- Out of range: read address 0x100 with MEM_DEPTH=256 -> readdata=0, response=10. Write to 0x3FF_FFFF followed by a read of index 0xFF -> location 0xFF unchanged.
- Back-to-back reads of 0x01..0x04 with WAIT_CYCLES=0 -> accept every 2 cycles, four readdatavalid pulses spaced 2 cycles apart, data in order.
- Assert reset one cycle after a read accept -> no readdatavalid afterwards, waitrequest=1, and memory still holds prior data on a re-read.
- With AVS_ACCESS_STATS_EN, issue 3 reads and 2 writes -> rd_count=3, wr_count=2. Without the macro, both remain 0.
